tiled_gemm_controller: RTL and testbench

//  Parametrised successor of the single-tile global controller. Sequences a full tiled GEMM
//  (N tiles outer, M tiles inner, K reduction per tile) on the ARRAY_ROW x ARRAY_COL systolic

---
 rtl/tiled_gemm_controller_pkg.sv | 17 +
 rtl/tiled_gemm_controller_stall_counter.sv | 32 +++
 rtl/tiled_gemm_controller.sv | 144 ++++++++++++++
 tb/tb_tiled_gemm_controller.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiled_gemm_controller_pkg.sv
// Shared definitions for the tiled GEMM controller: state encoding and array defaults.
package tiled_gemm_controller_pkg;

   localparam int ARRAY_ROW_DEF = 16;
   localparam int ARRAY_COL_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_CLEAR   = 3'd2,
      S_COMPUTE = 3'd3,
      S_FLUSH   = 3'd4,
      S_DRAIN   = 3'd5,
      S_DONE    = 3'd6
   } state_e;

endpackage

// File: rtl/tiled_gemm_controller_stall_counter.sv
// Beat counter that only advances on enabled cycles; flags the beat that reaches last_val.
module stall_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] last_val,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last = en & (cnt_q == last_val);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tiled_gemm_controller.sv
// Tiled GEMM sequencer: N tiles outer, M tiles inner, K reduction per tile, with
// weight reuse across M tiles and valid/full throttled streams.
module tiled_gemm_controller
   import tiled_gemm_controller_pkg::*;
#(
   parameter int ARRAY_ROW = ARRAY_ROW_DEF,
   parameter int ARRAY_COL = ARRAY_COL_DEF,
   parameter int CNT_W     = 16,
   parameter int FLUSH_CYC = ARRAY_ROW + ARRAY_COL - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ap_start,
   input  logic [CNT_W-1:0] cfg_k_dim,
   input  logic [CNT_W-1:0] cfg_m_tiles,
   input  logic [CNT_W-1:0] cfg_n_tiles,
   input  logic             w_valid,
   input  logic             in_valid,
   input  logic             out_full,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             err_cfg,
   output logic [2:0]       state_dbg,
   output logic             ctrl_weight_load_en,
   output logic             ctrl_input_stream_en,
   output logic             ctrl_acc_clear,
   output logic             ctrl_drain_en,
   output logic [CNT_W-1:0] tile_m_idx,
   output logic [CNT_W-1:0] tile_n_idx
);

   localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ARRAY_ROW - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] k_dim_q, k_dim_d, m_tiles_q, m_tiles_d, n_tiles_q, n_tiles_d;
   logic [CNT_W-1:0] m_idx_q, m_idx_d, n_idx_q, n_idx_d;
   logic             err_q, err_d, done_seen_q, done_seen_d;
   logic             w_last, k_last, f_last, d_last;

   // Each counter is held at zero outside its owning state, so it starts fresh on every entry.
   stall_counter #(.CNT_W(CNT_W)) u_w_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != S_LOAD_W),
      .en((state_q == S_LOAD_W) & w_valid), .last_val(ROW_LAST), .last(w_last));

   stall_counter #(.CNT_W(CNT_W)) u_k_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != S_COMPUTE),
      .en((state_q == S_COMPUTE) & in_valid), .last_val(k_dim_q - CNT_W'(1)), .last(k_last));

   stall_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != S_FLUSH),
      .en(state_q == S_FLUSH), .last_val(FLUSH_LAST), .last(f_last));

   stall_counter #(.CNT_W(CNT_W)) u_d_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != S_DRAIN),
      .en((state_q == S_DRAIN) & ~out_full), .last_val(ROW_LAST), .last(d_last));

   always_comb begin
      state_d     = state_q;
      k_dim_d     = k_dim_q;
      m_tiles_d   = m_tiles_q;
      n_tiles_d   = n_tiles_q;
      m_idx_d     = m_idx_q;
      n_idx_d     = n_idx_q;
      err_d       = err_q;
      done_seen_d = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               k_dim_d   = cfg_k_dim;
               m_tiles_d = cfg_m_tiles;
               n_tiles_d = cfg_n_tiles;
               m_idx_d   = '0;
               n_idx_d   = '0;
               err_d     = 1'b0;
               if ((cfg_k_dim == '0) || (cfg_m_tiles == '0) || (cfg_n_tiles == '0)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD_W;
               end
            end
         end
         S_LOAD_W:  if (w_last) state_d = S_CLEAR;
         S_CLEAR:   state_d = S_COMPUTE;
         S_COMPUTE: if (k_last) state_d = S_FLUSH;
         S_FLUSH:   if (f_last) state_d = S_DRAIN;
         S_DRAIN: begin
            // M is the inner loop so the loaded weights are reused until M wraps.
            if (d_last) begin
               if (m_idx_q != m_tiles_q - CNT_W'(1)) begin
                  m_idx_d = m_idx_q + CNT_W'(1);
                  state_d = S_CLEAR;
               end else begin
                  m_idx_d = '0;
                  if (n_idx_q != n_tiles_q - CNT_W'(1)) begin
                     n_idx_d = n_idx_q + CNT_W'(1);
                     state_d = S_LOAD_W;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_DONE:    if (!ap_start) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         m_idx_q     <= '0;
         n_idx_q     <= '0;
         err_q       <= 1'b0;
         done_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         m_idx_q     <= m_idx_d;
         n_idx_q     <= n_idx_d;
         err_q       <= err_d;
         done_seen_q <= done_seen_d;
      end
   end

   // Latched configuration is data only; it is always written before it is used.
   always_ff @(posedge clk) begin
      k_dim_q   <= k_dim_d;
      m_tiles_q <= m_tiles_d;
      n_tiles_q <= n_tiles_d;
   end

   assign ap_idle              = (state_q == S_IDLE);
   assign ap_done              = (state_q == S_DONE) & ~done_seen_q;
   assign err_cfg              = err_q;
   assign state_dbg            = state_q;
   assign ctrl_weight_load_en  = (state_q == S_LOAD_W);
   assign ctrl_input_stream_en = (state_q == S_COMPUTE);
   assign ctrl_acc_clear       = (state_q == S_CLEAR);
   assign ctrl_drain_en        = (state_q == S_DRAIN) & ~out_full;
   assign tile_m_idx           = m_idx_q;
   assign tile_n_idx           = n_idx_q;

endmodule

// File: tb/tb_tiled_gemm_controller.sv
// Self-checking bench for tiled_gemm_controller: phase-schedule reference model plus directed literals.
module tb_tiled_gemm_controller;

   localparam int ROWS = 16;
   localparam int FL   = 31;
   localparam int K_IDLE = 0, K_LOADW = 1, K_CLEAR = 2, K_COMP = 3, K_FLUSH = 4, K_DRAIN = 5, K_DONE = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ap_start = 1'b0;
   logic [15:0] cfg_k_dim = '0, cfg_m_tiles = '0, cfg_n_tiles = '0;
   logic        w_valid = 1'b1, in_valid = 1'b1, out_full = 1'b0;
   logic        ap_done, ap_idle, err_cfg;
   logic [2:0]  state_dbg;
   logic        ctrl_weight_load_en, ctrl_input_stream_en, ctrl_acc_clear, ctrl_drain_en;
   logic [15:0] tile_m_idx, tile_n_idx;

   tiled_gemm_controller dut (
      .clk(clk), .rst_n(rst_n), .ap_start(ap_start),
      .cfg_k_dim(cfg_k_dim), .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles),
      .w_valid(w_valid), .in_valid(in_valid), .out_full(out_full),
      .ap_done(ap_done), .ap_idle(ap_idle), .err_cfg(err_cfg), .state_dbg(state_dbg),
      .ctrl_weight_load_en(ctrl_weight_load_en), .ctrl_input_stream_en(ctrl_input_stream_en),
      .ctrl_acc_clear(ctrl_acc_clear), .ctrl_drain_en(ctrl_drain_en),
      .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx));

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is a list of phases, each lasting a number of beats.
   typedef struct {
      int kind;
      int cnt;
      int n;
      int m;
   } phase_t;

   phase_t q[$];
   bit     m_err = 1'b0;
   bit     m_first = 1'b0;
   int     m_n = 0, m_m = 0;

   function automatic void build(input int k, input int mt, input int nt);
      m_err   = (k == 0) || (mt == 0) || (nt == 0);
      m_first = 1'b1;
      if (m_err) begin
         q.push_back('{K_DONE, 0, 0, 0});
      end else begin
         for (int n = 0; n < nt; n++) begin
            q.push_back('{K_LOADW, ROWS, n, 0});
            for (int m = 0; m < mt; m++) begin
               q.push_back('{K_CLEAR, 1, n, m});
               q.push_back('{K_COMP, k, n, m});
               q.push_back('{K_FLUSH, FL, n, m});
               q.push_back('{K_DRAIN, ROWS, n, m});
            end
         end
         q.push_back('{K_DONE, 0, nt - 1, 0});
      end
   endfunction

   bit beat;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_err = 1'b0; m_first = 1'b0; m_n = 0; m_m = 0;
      end else if (q.size() == 0) begin
         if (ap_start) build(int'(cfg_k_dim), int'(cfg_m_tiles), int'(cfg_n_tiles));
      end else if (q[0].kind == K_DONE) begin
         m_first = 1'b0;
         if (!ap_start) void'(q.pop_front());
      end else begin
         case (q[0].kind)
            K_LOADW: beat = w_valid;
            K_COMP:  beat = in_valid;
            K_DRAIN: beat = !out_full;
            default: beat = 1'b1;
         endcase
         if (beat) begin
            q[0].cnt = q[0].cnt - 1;
            if (q[0].cnt == 0) void'(q.pop_front());
         end
      end
      if (rst_n && q.size() > 0) begin
         m_n = q[0].n;
         m_m = q[0].m;
      end
   end

   int ek;
   always @(negedge clk) begin
      ek = (q.size() > 0) ? q[0].kind : K_IDLE;
      check("state_dbg", int'(state_dbg), ek);
      check("ap_idle", int'(ap_idle), int'(ek == K_IDLE));
      check("ap_done", int'(ap_done), int'(ek == K_DONE && m_first));
      check("err_cfg", int'(err_cfg), int'(m_err));
      check("weight_load_en", int'(ctrl_weight_load_en), int'(ek == K_LOADW));
      check("input_stream_en", int'(ctrl_input_stream_en), int'(ek == K_COMP));
      check("acc_clear", int'(ctrl_acc_clear), int'(ek == K_CLEAR));
      check("drain_en", int'(ctrl_drain_en), int'(ek == K_DRAIN && !out_full));
      check("tile_m_idx", int'(tile_m_idx), m_m);
      check("tile_n_idx", int'(tile_n_idx), m_n);
   end

   // Observed event counts, compared against hand-computed literals per scenario.
   int ob_loads, ob_wbeats, ob_clears, ob_kbeats, ob_kcyc, ob_fcyc, ob_dcyc, ob_dbeats, ob_done, ob_strobes;
   int clr_n[$], clr_m[$];
   logic [2:0] prev_state = 3'd0;

   always @(negedge clk) begin
      if (state_dbg == 3'd1 && prev_state != 3'd1) ob_loads++;
      if (ctrl_weight_load_en && w_valid) ob_wbeats++;
      if (ctrl_acc_clear) begin
         ob_clears++;
         clr_n.push_back(int'(tile_n_idx));
         clr_m.push_back(int'(tile_m_idx));
      end
      if (ctrl_input_stream_en && in_valid) ob_kbeats++;
      if (state_dbg == 3'd3) ob_kcyc++;
      if (state_dbg == 3'd4) ob_fcyc++;
      if (state_dbg == 3'd5) ob_dcyc++;
      if (ctrl_drain_en) ob_dbeats++;
      if (ap_done) ob_done++;
      if (ctrl_weight_load_en || ctrl_input_stream_en || ctrl_acc_clear || ctrl_drain_en) ob_strobes++;
      prev_state = state_dbg;
   end

   task automatic clear_obs();
      ob_loads = 0; ob_wbeats = 0; ob_clears = 0; ob_kbeats = 0; ob_kcyc = 0;
      ob_fcyc = 0; ob_dcyc = 0; ob_dbeats = 0; ob_done = 0; ob_strobes = 0;
      clr_n.delete(); clr_m.delete();
   endtask

   // Stimulus modes: 0 = fixed, 1 = random, 2 = scripted (toggle / stall window)
   int wv_mode = 0, iv_mode = 0, full_mode = 0;
   int full_left = 0;
   bit full_used = 1'b0;

   always @(posedge clk) begin
      #1;
      w_valid = (wv_mode == 0) ? 1'b1 : (($urandom % 4) != 0);
      case (iv_mode)
         0: in_valid = 1'b1;
         1: in_valid = (($urandom % 3) != 0);
         default: in_valid = ~in_valid;
      endcase
      case (full_mode)
         0: out_full = 1'b0;
         1: out_full = (($urandom % 4) == 0);
         default: begin
            if (full_left > 0) begin
               out_full = 1'b1;
               full_left--;
            end else if (ob_dbeats == 5 && !full_used) begin
               full_used = 1'b1;
               full_left = 19;
               out_full  = 1'b1;
            end else begin
               out_full = 1'b0;
            end
         end
      endcase
   end

   task automatic run_job(input string tag, input int k, input int mt, input int nt);
      int cyc;
      clear_obs();
      @(posedge clk); #1;
      cfg_k_dim = 16'(k); cfg_m_tiles = 16'(mt); cfg_n_tiles = 16'(nt);
      ap_start = 1'b1;
      @(posedge clk); #1;
      ap_start = 1'b0;
      cfg_k_dim = 16'($urandom); cfg_m_tiles = 16'($urandom); cfg_n_tiles = 16'($urandom);
      cyc = 0;
      while (ob_done == 0 && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      check({tag, "_done_seen"}, int'(ob_done > 0), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   int kk, mm, nn, cyc6;

   initial begin
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", int'(state_dbg), 0);
      check("rst_idle", int'(ap_idle), 1);
      check("rst_done", int'(ap_done), 0);
      check("rst_strobes", int'(ctrl_weight_load_en | ctrl_input_stream_en | ctrl_acc_clear | ctrl_drain_en), 0);
      check("rst_tile", int'(tile_m_idx) + int'(tile_n_idx), 0);
      rst_n = 1'b1;

      // 1: single tile, everything always ready
      run_job("t1", 4, 1, 1);
      check("t1_wbeats", ob_wbeats, 16);
      check("t1_loads", ob_loads, 1);
      check("t1_clears", ob_clears, 1);
      check("t1_kbeats", ob_kbeats, 4);
      check("t1_kcyc", ob_kcyc, 4);
      check("t1_fcyc", ob_fcyc, 31);
      check("t1_dbeats", ob_dbeats, 16);
      check("t1_dcyc", ob_dcyc, 16);
      check("t1_done", ob_done, 1);

      // 2: 3 N tiles x 2 M tiles
      run_job("t2", 8, 2, 3);
      check("t2_loads", ob_loads, 3);
      check("t2_clears", ob_clears, 6);
      check("t2_dbeats", ob_dbeats, 96);
      check("t2_seq_len", clr_n.size(), 6);
      for (int i = 0; i < clr_n.size() && i < 6; i++) begin
         check("t2_seq_n", clr_n[i], i / 2);
         check("t2_seq_m", clr_m[i], i % 2);
      end

      // 3: in_valid toggling each cycle
      iv_mode = 2;
      run_job("t3", 10, 1, 1);
      check("t3_kbeats", ob_kbeats, 10);
      check("t3_kcyc_19_or_20", int'(ob_kcyc == 19 || ob_kcyc == 20), 1);
      check("t3_fcyc", ob_fcyc, 31);
      iv_mode = 0;

      // 4: out_full window of 20 cycles after drain beat 5
      full_mode = 2;
      run_job("t4", 4, 1, 1);
      check("t4_dbeats", ob_dbeats, 16);
      check("t4_dcyc", ob_dcyc, 36);
      full_mode = 0;

      // 5: zero K dimension, then a valid start clears the error
      run_job("t5", 0, 1, 1);
      check("t5_err", int'(err_cfg), 1);
      check("t5_done", ob_done, 1);
      check("t5_strobes", ob_strobes, 0);
      run_job("t5b", 3, 1, 1);
      check("t5b_err_cleared", int'(err_cfg), 0);
      check("t5b_clears", ob_clears, 1);

      // Randomised runs against the phase model
      wv_mode = 1; iv_mode = 1; full_mode = 1;
      for (int r = 0; r < 8; r++) begin
         kk = int'($urandom_range(1, 6));
         mm = int'($urandom_range(1, 3));
         nn = int'($urandom_range(1, 2));
         run_job("rnd", kk, mm, nn);
         check("rnd_loads", ob_loads, nn);
         check("rnd_clears", ob_clears, mm * nn);
         check("rnd_dbeats", ob_dbeats, mm * nn * ROWS);
         check("rnd_kbeats", ob_kbeats, kk * mm * nn);
      end
      wv_mode = 0; iv_mode = 0; full_mode = 0;

      // 6: async reset in the middle of COMPUTE
      clear_obs();
      @(posedge clk); #1;
      cfg_k_dim = 16'd50; cfg_m_tiles = 16'd1; cfg_n_tiles = 16'd1;
      ap_start = 1'b1;
      @(posedge clk); #1;
      ap_start = 1'b0;
      cyc6 = 0;
      while (state_dbg != 3'd3 && cyc6 < 200) begin
         @(posedge clk); #1;
         cyc6++;
      end
      check("t6_reach_compute", int'(state_dbg), 3);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_state", int'(state_dbg), 0);
      check("t6_idle", int'(ap_idle), 1);
      check("t6_strobes", int'(ctrl_weight_load_en | ctrl_input_stream_en | ctrl_acc_clear | ctrl_drain_en), 0);
      check("t6_done_low", int'(ap_done), 0);
      repeat (2) @(posedge clk);
      check("t6_no_done", ob_done, 0);
      #1 rst_n = 1'b1;

      // ap_start held high through DONE must not retrigger
      clear_obs();
      @(posedge clk); #1;
      cfg_k_dim = 16'd2; cfg_m_tiles = 16'd1; cfg_n_tiles = 16'd1;
      ap_start = 1'b1;
      cyc6 = 0;
      while (ob_done == 0 && cyc6 < 2000) begin
         @(posedge clk);
         cyc6++;
      end
      check("t6b_done_seen", int'(ob_done > 0), 1);
      repeat (40) @(posedge clk);
      #1;
      check("t6b_one_done", ob_done, 1);
      check("t6b_hold_done", int'(state_dbg), 6);
      check("t6b_one_load", ob_loads, 1);
      ap_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t6b_idle", int'(ap_idle), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
